// File: rtl/wb_commit_arbiter.sv
// wb_commit_arbiter: per-channel result FIFOs with round-robin single-commit write-back.
// Optional macro WB_COMMIT_BYPASS_EN lets an empty channel's incoming result commit at the accepting edge.
module wb_commit_arbiter #(
    parameter int NCH   = 2,
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5,
    localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    input  logic [NCH-1:0]    in_rf_we,
    input  logic [NCH*AW-1:0] in_waddr,
    input  logic [NCH*DW-1:0] in_wdata,
    input  logic [NCH-1:0]    in_hilo_we,
    input  logic [NCH*DW-1:0] in_hi,
    input  logic [NCH*DW-1:0] in_lo,
    output logic              regfile_wena,
    output logic [AW-1:0]     rf_waddr,
    output logic [DW-1:0]     rf_wdata,
    output logic              hi_w,
    output logic              lo_w,
    output logic [DW-1:0]     hi_out,
    output logic [DW-1:0]     lo_out,
    output logic [CW-1:0]     commit_ch,
    output logic              pending
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 2 + AW + 3 * DW;

    logic [EW-1:0]  mem [NCH][DEPTH];
    logic [PW:0]    wptr [NCH];
    logic [PW:0]    rptr [NCH];
    logic [EW-1:0]  din [NCH];
    logic [NCH-1:0] empty, full, push, elig;
    logic [CW-1:0]  rr, win, nxt;
    logic [EW-1:0]  head;
    logic           found, bypass;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        assign din[c]   = {in_rf_we[c], in_waddr[c*AW +: AW], in_wdata[c*DW +: DW],
                           in_hilo_we[c], in_hi[c*DW +: DW], in_lo[c*DW +: DW]};
        assign empty[c] = wptr[c] == rptr[c];
        // Extra pointer bit separates full (same index, different lap) from empty.
        assign full[c]  = (wptr[c][PW-1:0] == rptr[c][PW-1:0]) && (wptr[c][PW] != rptr[c][PW]);
        assign push[c]  = in_valid[c] && !full[c] && !(bypass && win == CW'(c));
    end

    assign in_ready = ~full;
    assign pending  = |(~empty);

`ifdef WB_COMMIT_BYPASS_EN
    assign elig   = ~empty | in_valid;
    assign bypass = found && empty[win];
    assign head   = bypass ? din[win] : mem[win][rptr[win][PW-1:0]];
`else
    assign elig   = ~empty;
    assign bypass = 1'b0;
    assign head   = mem[win][rptr[win][PW-1:0]];
`endif

    always_comb begin
        found = 1'b0;
        win   = rr;
        for (int i = 0; i < NCH; i++) begin
            if (!found && elig[(int'(rr) + i) % NCH]) begin
                found = 1'b1;
                win   = CW'((int'(rr) + i) % NCH);
            end
        end
    end

    assign nxt = (int'(win) == NCH - 1) ? '0 : win + CW'(1);

    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++)
            if (push[c] && !flush) mem[c][wptr[c][PW-1:0]] <= din[c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
            end
            rr           <= '0;
            regfile_wena <= 1'b0;
            hi_w         <= 1'b0;
            lo_w         <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            hi_out       <= '0;
            lo_out       <= '0;
            commit_ch    <= '0;
        end else if (flush) begin
            for (int c = 0; c < NCH; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
            end
            regfile_wena <= 1'b0;
            hi_w         <= 1'b0;
            lo_w         <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++)
                if (push[c]) wptr[c] <= wptr[c] + 1'b1;
            if (found) begin
                if (!bypass) rptr[win] <= rptr[win] + 1'b1;
                rr           <= nxt;
                // Writes to r0 are dropped but address/data are still shown.
                regfile_wena <= head[EW-1] && (head[EW-2 -: AW] != '0);
                rf_waddr     <= head[EW-2 -: AW];
                rf_wdata     <= head[3*DW -: DW];
                hi_w         <= head[2*DW];
                lo_w         <= head[2*DW];
                hi_out       <= head[2*DW-1 -: DW];
                lo_out       <= head[DW-1:0];
                commit_ch    <= win;
            end else begin
                regfile_wena <= 1'b0;
                hi_w         <= 1'b0;
                lo_w         <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_commit_arbiter.sv
// tb_wb_commit_arbiter: directed and random stimulus against a queue-level reference of the commit arbiter.
module tb_wb_commit_arbiter;
`ifdef WB_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
        logic        hw;
        logic [31:0] hi;
        logic [31:0] lo;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [1:0]  in_valid, in_ready, in_rf_we, in_hilo_we;
    logic [9:0]  in_waddr;
    logic [63:0] in_wdata, in_hi, in_lo;
    logic        regfile_wena, hi_w, lo_w, pending;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, hi_out, lo_out;
    logic [0:0]  commit_ch;

    int total = 0;
    int bad = 0;

    ent_t        mq [2][4];
    int          cnt [2];
    int          rr_m;
    ent_t        e;
    logic        e_we, e_hw;
    logic [0:0]  e_ch;

    wb_commit_arbiter dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_rf_we(in_rf_we), .in_waddr(in_waddr), .in_wdata(in_wdata), .in_hilo_we(in_hilo_we),
        .in_hi(in_hi), .in_lo(in_lo), .regfile_wena(regfile_wena), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .hi_w(hi_w), .lo_w(lo_w), .hi_out(hi_out), .lo_out(lo_out),
        .commit_ch(commit_ch), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int c, input bit v, input bit we, input logic [4:0] a,
                          input logic [31:0] d, input bit hw, input logic [31:0] h, input logic [31:0] l);
        in_valid[c]       = v;
        in_rf_we[c]       = we;
        in_waddr[c*5 +: 5] = a;
        in_wdata[c*32 +: 32] = d;
        in_hilo_we[c]     = hw;
        in_hi[c*32 +: 32] = h;
        in_lo[c*32 +: 32] = l;
    endtask

    task automatic idle();
        set_ch(0, 0, 0, 0, 0, 0, 0, 0);
        set_ch(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        cnt[0] = 0; cnt[1] = 0; rr_m = 0;
        e = '0; e_we = 0; e_hw = 0; e_ch = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".wena"}, 32'(regfile_wena), 32'(e_we));
        chk({tag, ".waddr"}, 32'(rf_waddr), 32'(e.a));
        chk({tag, ".wdata"}, rf_wdata, e.d);
        chk({tag, ".hi_w"}, 32'(hi_w), 32'(e_hw));
        chk({tag, ".lo_w"}, 32'(lo_w), 32'(e_hw));
        chk({tag, ".hi"}, hi_out, e.hi);
        chk({tag, ".lo"}, lo_out, e.lo);
        chk({tag, ".ch"}, 32'(commit_ch), 32'(e_ch));
        chk({tag, ".pending"}, 32'(pending), 32'((cnt[0] > 0) || (cnt[1] > 0)));
    endtask

    // One clock of the reference: decide winner and pushes from current inputs, then compare after the edge.
    task automatic step(input string tag);
        ent_t inp [2];
        bit   rdy [2];
        int   w;
        bit   byp;
        for (int c = 0; c < 2; c++) begin
            inp[c] = {in_rf_we[c], in_waddr[c*5 +: 5], in_wdata[c*32 +: 32],
                      in_hilo_we[c], in_hi[c*32 +: 32], in_lo[c*32 +: 32]};
            rdy[c] = cnt[c] < 4;
        end
        chk({tag, ".ready"}, 32'(in_ready), 32'({rdy[1], rdy[0]}));
        w = -1;
        byp = 0;
        e_we = 0;
        e_hw = 0;
        if (flush) begin
            cnt[0] = 0; cnt[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                int c = (rr_m + i) % 2;
                if (w < 0 && (cnt[c] > 0 || (BYP && in_valid[c]))) w = c;
            end
            if (w >= 0) begin
                if (cnt[w] > 0) begin
                    e = mq[w][0];
                    for (int k = 0; k < 3; k++) mq[w][k] = mq[w][k+1];
                    cnt[w]--;
                end else begin
                    e = inp[w];
                    byp = 1;
                end
                e_we = e.we && (e.a != 0);
                e_hw = e.hw;
                e_ch = 1'(w);
                rr_m = (w + 1) % 2;
            end
            for (int c = 0; c < 2; c++)
                if (in_valid[c] && rdy[c] && !(byp && w == c)) begin
                    mq[c][cnt[c]] = inp[c];
                    cnt[c]++;
                end
        end
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    initial begin
        rst = 1; flush = 0;
        model_reset();
        set_ch(0, 1, 1, 5'd9, 32'h1, 1, 32'h2, 32'h3);
        set_ch(1, 1, 1, 5'd8, 32'h4, 1, 32'h5, 32'h6);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst.wena", 32'(regfile_wena), 0);
            chk("rst.hi_w", 32'(hi_w), 0);
        end
        idle();
        rst = 0;
        #1;
        chk("rel.ready", 32'(in_ready), 32'h3);
        check_outs("rel");

        set_ch(0, 1, 1, 5'd5, 32'h1234, 0, 0, 0);
        step("single.push");
        idle();
        step("single.c1");
        chk("single.addr", 32'(rf_waddr), 32'd5);
        step("single.c2");

        set_ch(0, 1, 1, 5'd3, 32'h33, 0, 0, 0);
        set_ch(1, 1, 1, 5'd7, 32'h77, 0, 0, 0);
        step("cont.push");
        idle();
        repeat (3) step("cont");

        for (int i = 0; i < 10; i++) begin
            set_ch(0, 1, 1, 5'(i + 1), 32'(100 + i), 0, 0, 0);
            set_ch(1, 1, 1, 5'(i + 11), 32'(200 + i), 0, 0, 0);
            step("full");
        end
        idle();
        repeat (12) step("drain");

        set_ch(1, 1, 1, 5'd0, 32'hDEAD, 1, 32'hAAAA0000, 32'h0000BBBB);
        step("r0.push");
        idle();
        step("r0.c");
        chk("r0.wena", 32'(regfile_wena), 0);
        chk("r0.hi", hi_out, 32'hAAAA0000);
        step("r0.idle");

        for (int i = 0; i < 3; i++) begin
            set_ch(0, 1, 1, 5'(i + 20), 32'(300 + i), 0, 0, 0);
            set_ch(1, 1, 1, 5'(i + 24), 32'(400 + i), 0, 0, 0);
            step("fl.fill");
        end
        flush = 1;
        step("fl.flush");
        flush = 0;
        idle();
        chk("fl.pending", 32'(pending), 0);
        repeat (2) step("fl.after");

        for (int n = 0; n < 300; n++) begin
            flush = ($urandom_range(0, 15) == 0);
            for (int c = 0; c < 2; c++)
                set_ch(c, $urandom_range(0, 2) != 0, 1'($urandom), 5'($urandom_range(0, 3)),
                       $urandom, 1'($urandom), $urandom, $urandom);
            step("rnd");
        end
        flush = 0;
        set_ch(0, 1, 1, 5'd2, 32'h55, 1, 32'h66, 32'h77);
        set_ch(1, 1, 1, 5'd4, 32'h88, 0, 0, 0);
        step("mid.push");
        #2 rst = 1;
        #1;
        model_reset();
        check_outs("mid.rst");
        idle();
        #1 rst = 0;
        repeat (2) step("mid.after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
